// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle big-endian data memory with req/ack handshake
// and a programmable wait-state counter. Byte/halfword/word loads and stores.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   a_idx;
  logic [1:0]      a_off;
  logic [31:0]     a_din;
  logic [1:0]      a_size;
  logic            a_sext;
  logic            a_wr;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     rword_c;
  logic [31:0]     wword_c;
  logic [31:0]     ldata_c;
  logic [7:0]      bsel_c;
  logic [15:0]     hsel_c;
  logic            bad_c;
  logic            done_c;
  logic            we_c;

  // Address bits above the array are intentionally ignored (address wrap)
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  // Misaligned detection: halfword on odd byte, word off a word boundary
`ifdef DMEM_ALIGN_CHECK_EN
  assign bad_c = ((a_size == 2'b01) && a_off[0]) ||
                 (a_size[1] && (a_off != 2'b00));
`else
  assign bad_c = 1'b0;
`endif

  assign done_c = (state == S_WAIT) && (cnt == '0);
  assign we_c   = done_c && a_wr && !bad_c && !reset;

  // Big-endian lane select for loads and lane merge for stores
  always_comb begin
    rword_c = mem[a_idx];
    wword_c = rword_c;
    ldata_c = rword_c;
    bsel_c  = 8'h00;
    hsel_c  = 16'h0000;
    unique case (a_size)
      2'b00: begin
        unique case (a_off)
          2'd0: begin bsel_c = rword_c[31:24]; wword_c[31:24] = a_din[7:0]; end
          2'd1: begin bsel_c = rword_c[23:16]; wword_c[23:16] = a_din[7:0]; end
          2'd2: begin bsel_c = rword_c[15:8];  wword_c[15:8]  = a_din[7:0]; end
          default: begin bsel_c = rword_c[7:0]; wword_c[7:0] = a_din[7:0]; end
        endcase
        ldata_c = a_sext ? {{24{bsel_c[7]}}, bsel_c} : {24'h000000, bsel_c};
      end
      2'b01: begin
        if (a_off[1]) begin
          hsel_c = rword_c[15:0];
          wword_c[15:0] = a_din[15:0];
        end else begin
          hsel_c = rword_c[31:16];
          wword_c[31:16] = a_din[15:0];
        end
        ldata_c = a_sext ? {{16{hsel_c[15]}}, hsel_c} : {16'h0000, hsel_c};
      end
      default: begin
        wword_c = a_din;
        ldata_c = rword_c;
      end
    endcase
  end

  // Word array: never reset, written only on a completing legal store
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[a_idx] <= wword_c;
    end
  end

  // Control FSM with registered handshake outputs and load data
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_idx  <= '0;
      a_off  <= 2'b00;
      a_din  <= 32'h0;
      a_size <= 2'b00;
      a_sext <= 1'b0;
      a_wr   <= 1'b0;
      dout   <= 32'h0;
      ack    <= 1'b0;
      busy   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      fault  <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      fault <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (cs && (rd ^ wr)) begin
            a_idx  <= addr[AW+1:2];
            a_off  <= addr[1:0];
            a_din  <= din;
            a_size <= size;
            a_sext <= sext;
            a_wr   <= wr;
            cnt    <= CW'(WAIT_STATES);
            busy   <= 1'b1;
            state  <= S_WAIT;
          end
        end
        default: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            ack   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
            if (!a_wr && !bad_c) begin
              dout <= ldata_c;
            end
`ifdef DMEM_ALIGN_CHECK_EN
            fault <= bad_c;
`endif
          end
        end
      endcase
    end
  end

`ifndef DMEM_ALIGN_CHECK_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: stimulus pushes hand-computed expected
// {fault, dout} per accepted request; a monitor pops and compares on each ack.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, rd, wr, sext;
  logic [1:0]  size;
  logic [31:0] addr, din;
  logic [31:0] dout;
  logic        ack, busy, fault;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q [$];

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .size(size),
    .sext(sext), .addr(addr), .din(din), .dout(dout), .ack(ack),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && ack) begin
      if (exp_q.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("dout", dout, e[31:0]);
        chk("fault", {31'd0, fault}, {31'd0, e[32]});
      end
    end
  end

  task automatic idle_inputs();
    cs = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 32'h0; din = 32'h0;
  endtask

  // Issue one legal request, check handshake timing, queue expected result
  task automatic req(input logic i_wr, input logic [1:0] i_size, input logic i_sext,
                     input logic [31:0] i_addr, input logic [31:0] i_din,
                     input logic [31:0] e_dout, input logic e_fault,
                     input logic overlap);
    int cycles;
    int busy_hi;
    logic got;
    @(negedge clk);
    cs = 1'b1; rd = ~i_wr; wr = i_wr; size = i_size; sext = i_sext;
    addr = i_addr; din = i_din;
    @(posedge clk);
    exp_q.push_back({e_fault, e_dout});
    #1;
    idle_inputs();
    if (overlap) begin
      cs = 1'b1; rd = 1'b1; size = 2'b10; addr = 32'h10;
    end
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    cycles = 0; busy_hi = 1; got = 1'b0;
    while (!got && cycles < 20) begin
      @(posedge clk); #1;
      idle_inputs();
      cycles++;
      if (ack) got = 1'b1;
      else if (busy) busy_hi++;
    end
    chk("ack_latency", 32'(cycles), 32'(WS + 1));
    chk("busy_cycles", 32'(busy_hi), 32'(WS + 1));
    chk("busy_in_ack_cycle", {31'd0, busy}, 32'd0);
  endtask

  // Present a request that must be ignored; no busy and no ack may follow
  task automatic ign(input logic i_cs, input logic i_rd, input logic i_wr);
    logic seen;
    @(negedge clk);
    cs = i_cs; rd = i_rd; wr = i_wr; size = 2'b10; addr = 32'h10; din = 32'h5555AAAA;
    @(posedge clk); #1;
    idle_inputs();
    chk("ignored_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < WS + 3; i++) begin
      @(posedge clk); #1;
      if (ack || busy) seen = 1'b1;
    end
    chk("ignored_no_activity", {31'd0, seen}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", dout, 32'h0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word store/load
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);

    // Sub-word accesses on word 0x20
    req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b0);
    req(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000A5, 32'hDEADBEEF, 1'b0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h11A53344, 1'b0, 1'b0);
    req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        32'hFFFFFFA5, 1'b0, 1'b0);
    req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'h00003344, 1'b0, 1'b0);
    req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'h000000A5, 1'b0, 1'b0);
    req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h000011A5, 1'b0, 1'b0);
    req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF8001, 32'h000011A5, 1'b0, 1'b0);
    req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 1'b0);
    req(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000007E, 32'hFFFF8001, 1'b0, 1'b0);
    req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        32'h11A5807E, 1'b0, 1'b0);

    // Request while busy is dropped: exactly one ack, then idle
    req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h11A5807E, 1'b0, 1'b1);
    ign(1'b0, 1'b0, 1'b0);

    // Illegal requests
    ign(1'b1, 1'b1, 1'b1);
    ign(1'b0, 1'b1, 1'b0);

    // Address wrap aliases 0x10
    req(1'b0, 2'b10, 1'b0, 32'h10 + DEPTH * 4, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Reset during a pending store discards it
    req(1'b1, 2'b10, 1'b0, 32'h30, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h30; din = 32'h12345678;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_ack", {31'd0, ack}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_dout", dout, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ign(1'b0, 1'b0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h00000000, 1'b0, 1'b0);

    // Misaligned word load
    req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
`else
    req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
`endif

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
